fifo_sync_prog: RTL



---
 rtl/fifo_sync_prog_if.sv | 37 +++
 rtl/fifo_sync_prog.sv | 128 ++++++++++++
 2 files changed

// File: rtl/fifo_sync_prog_if.sv
// Producer/consumer-side bundle of the programmable synchronous FIFO.
// master = the FIFO user, slave = the FIFO itself.
interface fifo_sync_prog_if #(
  parameter int unsigned FIFO_WIDTH = 16,
  parameter int unsigned FIFO_DEPTH = 8
);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  logic                  clr;
  logic [FIFO_WIDTH-1:0] data_in;
  logic                  wr_en;
  logic                  rd_en;
  logic [CNT_W-1:0]      af_level;
  logic [CNT_W-1:0]      ae_level;

  logic [FIFO_WIDTH-1:0] data_out;
  logic                  wr_ack;
  logic                  overflow;
  logic                  underflow;
  logic                  full;
  logic                  empty;
  logic                  almostfull;
  logic                  almostempty;
  logic [CNT_W-1:0]      level;

  modport master (
    output clr, data_in, wr_en, rd_en, af_level, ae_level,
    input  data_out, wr_ack, overflow, underflow,
    input  full, empty, almostfull, almostempty, level
  );

  modport slave (
    input  clr, data_in, wr_en, rd_en, af_level, ae_level,
    output data_out, wr_ack, overflow, underflow,
    output full, empty, almostfull, almostempty, level
  );
endinterface

// File: rtl/fifo_sync_prog.sv
// Single-clock FIFO of arbitrary depth with programmable almost-full/almost-empty,
// fill level and synchronous flush. Define FIFO_FWFT_EN for first-word-fall-through reads.
module fifo_sync_prog #(
  parameter int unsigned FIFO_WIDTH = 16,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input logic             clk,
  input logic             rst_n,
  fifo_sync_prog_if.slave bus
);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0] LVL_FULL = CNT_W'(FIFO_DEPTH);

  logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr_nxt;
  logic [PTR_W-1:0] rd_ptr_nxt;
  logic [CNT_W-1:0] level_q;
  logic [CNT_W-1:0] level_nxt;

  logic full_c;
  logic empty_c;
  logic wr_ok_c;
  logic rd_ok_c;

  logic wr_ack_q;
  logic overflow_q;
  logic underflow_q;
  logic wr_ack_nxt;
  logic overflow_nxt;
  logic underflow_nxt;

  // Explicit wrap so non-power-of-2 depths never index past the last entry.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  assign full_c  = (level_q == LVL_FULL);
  assign empty_c = (level_q == '0);

  // Flush takes priority, so it masks both requests.
  always_comb begin
    wr_ok_c       = 1'b0;
    rd_ok_c       = 1'b0;
    wr_ack_nxt    = 1'b0;
    overflow_nxt  = 1'b0;
    underflow_nxt = 1'b0;
    if (!bus.clr) begin
      wr_ok_c       = bus.wr_en & ~full_c;
      rd_ok_c       = bus.rd_en & ~empty_c;
      wr_ack_nxt    = wr_ok_c;
      overflow_nxt  = bus.wr_en & full_c;
      underflow_nxt = bus.rd_en & empty_c;
    end
  end

  always_comb begin
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    level_nxt  = level_q;
    if (bus.clr) begin
      wr_ptr_nxt = '0;
      rd_ptr_nxt = '0;
      level_nxt  = '0;
    end else begin
      if (wr_ok_c) wr_ptr_nxt = ptr_inc(wr_ptr);
      if (rd_ok_c) rd_ptr_nxt = ptr_inc(rd_ptr);
      if (wr_ok_c && !rd_ok_c) begin
        level_nxt = level_q + CNT_W'(1);
      end else if (rd_ok_c && !wr_ok_c) begin
        level_nxt = level_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level_q     <= '0;
      wr_ack_q    <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr      <= wr_ptr_nxt;
      rd_ptr      <= rd_ptr_nxt;
      level_q     <= level_nxt;
      wr_ack_q    <= wr_ack_nxt;
      overflow_q  <= overflow_nxt;
      underflow_q <= underflow_nxt;
    end
  end

  // Storage is deliberately unreset; flush and reset only move pointers.
  always_ff @(posedge clk) begin
    if (wr_ok_c) mem[wr_ptr] <= bus.data_in;
  end

`ifdef FIFO_FWFT_EN
  assign bus.data_out = empty_c ? '0 : mem[rd_ptr];
`else
  logic [FIFO_WIDTH-1:0] data_out_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out_q <= '0;
    end else if (rd_ok_c) begin
      data_out_q <= mem[rd_ptr];
    end
  end

  assign bus.data_out = data_out_q;
`endif

  assign bus.wr_ack      = wr_ack_q;
  assign bus.overflow    = overflow_q;
  assign bus.underflow   = underflow_q;
  assign bus.full        = full_c;
  assign bus.empty       = empty_c;
  assign bus.almostfull  = (level_q >= bus.af_level);
  assign bus.almostempty = (level_q <= bus.ae_level);
  assign bus.level       = level_q;

endmodule
